// File: rtl/bus_reg_bank.sv
// Byte-wide register bank: scratch registers, access counters, a latched 16-bit
// timer and a small FIFO behind a data/status register pair.
module bus_reg_bank #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  ID_VALUE   = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] int_address,
    input  logic [7:0] int_wr_data,
    input  logic       int_write,
    input  logic       int_read,
    output logic [7:0] int_rd_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [7:0] A_ID     = 8'h10;
    localparam logic [7:0] A_WRCNT  = 8'h11;
    localparam logic [7:0] A_RDCNT  = 8'h12;
    localparam logic [7:0] A_TMR_LO = 8'h13;
    localparam logic [7:0] A_TMR_HI = 8'h14;
    localparam logic [7:0] A_FIFO   = 8'h20;
    localparam logic [7:0] A_STAT   = 8'h21;

    logic [7:0]       scratch [16];
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [7:0]       wr_count;
    logic [7:0]       rd_count;
    logic [15:0]      timer;
    logic [7:0]       shadow;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic             underflow;
    logic [7:0]       rd_data_p1;

    logic             wr_en_p0;
    logic             rd_en_p0;
    logic             is_scratch_p0;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_p0;
    logic             pop_p0;
    logic [3:0]       count4;
    logic [7:0]       rd_sel_p0;

    // Decode stage: a simultaneous write and read is treated as a write only.
    always_comb begin
        wr_en_p0      = int_write;
        rd_en_p0      = int_read & ~int_write;
        is_scratch_p0 = (int_address[7:4] == 4'h0);
        fifo_full     = (fifo_count == FULL_CNT);
        fifo_empty    = (fifo_count == '0);
        push_p0       = wr_en_p0 && (int_address == A_FIFO) && !fifo_full;
        pop_p0        = rd_en_p0 && (int_address == A_FIFO) && !fifo_empty;
        count4        = 4'(fifo_count);
        rd_sel_p0     = 8'h00;
        if (is_scratch_p0) begin
            rd_sel_p0 = scratch[int_address[3:0]];
        end else begin
            case (int_address)
                A_ID:     rd_sel_p0 = ID_VALUE;
                A_WRCNT:  rd_sel_p0 = wr_count;
                A_RDCNT:  rd_sel_p0 = rd_count;
                A_TMR_LO: rd_sel_p0 = timer[7:0];
                A_TMR_HI: rd_sel_p0 = shadow;
                A_FIFO:   rd_sel_p0 = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
                A_STAT:   rd_sel_p0 = {overflow, underflow, fifo_full, fifo_empty, count4};
                default:  rd_sel_p0 = 8'h00;
            endcase
        end
    end

    // Register stage: all architectural state, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) scratch[i] <= 8'h00;
            wr_count   <= 8'h00;
            rd_count   <= 8'h00;
            timer      <= 16'h0000;
            shadow     <= 8'h00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            rd_data_p1 <= 8'h00;
        end else begin
            timer <= timer + 16'd1;

            if (wr_en_p0) begin
                wr_count <= wr_count + 8'd1;
                if (is_scratch_p0) scratch[int_address[3:0]] <= int_wr_data;
                if (int_address == A_FIFO && fifo_full) overflow <= 1'b1;
                if (int_address == A_STAT) begin
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                end
            end

            if (rd_en_p0) begin
                rd_count   <= rd_count + 8'd1;
                rd_data_p1 <= rd_sel_p0;
                if (int_address == A_TMR_LO) shadow <= timer[15:8];
                if (int_address == A_FIFO && fifo_empty) underflow <= 1'b1;
            end

            // Push and pop are mutually exclusive, so count moves by at most one.
            if (push_p0) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                fifo_count <= fifo_count + CNT_W'(1);
            end
            if (pop_p0) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // FIFO storage holds data only; validity is tracked by the count.
    always_ff @(posedge clock) begin
        if (push_p0) fifo_mem[wr_ptr] <= int_wr_data;
    end

    assign int_rd_data = rd_data_p1;

endmodule
